// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// Optional grant counters are built only when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [4:0]  r0_shamt,
    input  logic [4:0]  r0_sel,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [4:0]  r1_shamt,
    input  logic [4:0]  r1_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_shamt,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_id,
    output logic [31:0] res_y,
    output logic        res_zero,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_r;
    logic        last_grant_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [4:0]  op_shamt_r;
    logic [4:0]  op_sel_r;
    logic        res_valid_r;
    logic        res_id_r;
    logic [31:0] res_y_r;
    logic        res_zero_r;
    logic        sel_valid_s;
    logic        sel_id_s;
    logic        accept_s;

    // Pick this cycle's candidate; on contention favour the one not granted last.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = 1'b0;
        if (r0_valid && r1_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = ~last_grant_r;
        end else if (r0_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = 1'b0;
        end else if (r1_valid) begin
            sel_valid_s = 1'b1;
            sel_id_s    = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
            sel_id_s    = 1'b0;
        end
    end

    assign accept_s = (state_r == IDLE) && sel_valid_s;
    assign r0_ready = accept_s && !sel_id_s;
    assign r1_ready = accept_s && sel_id_s;

    assign alu_a     = op_a_r;
    assign alu_b     = op_b_r;
    assign alu_shamt = op_shamt_r;
    assign alu_sel   = op_sel_r;
    assign res_valid = res_valid_r;
    assign res_id    = res_id_r;
    assign res_y     = res_y_r;
    assign res_zero  = res_zero_r;

    // Control FSM with operand and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            last_grant_r <= ~PRIO_INIT;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            op_shamt_r   <= 5'd0;
            op_sel_r     <= 5'd0;
            res_valid_r  <= 1'b0;
            res_id_r     <= 1'b0;
            res_y_r      <= 32'd0;
            res_zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_a_r       <= sel_id_s ? r1_a : r0_a;
                        op_b_r       <= sel_id_s ? r1_b : r0_b;
                        op_shamt_r   <= sel_id_s ? r1_shamt : r0_shamt;
                        op_sel_r     <= sel_id_s ? r1_sel : r0_sel;
                        last_grant_r <= sel_id_s;
                        res_id_r     <= sel_id_s;
                        state_r      <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    res_y_r     <= alu_y;
                    res_zero_r  <= alu_zero;
                    res_valid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_r;
    logic [15:0] cnt1_r;

    // Saturating per-requester accept counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_r <= 16'd0;
            cnt1_r <= 16'd0;
        end else begin
            if (r0_ready && (cnt0_r != 16'hFFFF)) begin
                cnt0_r <= cnt0_r + 16'd1;
            end
            if (r1_ready && (cnt1_r != 16'hFFFF)) begin
                cnt1_r <= cnt1_r + 16'd1;
            end
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`else
    assign cnt0 = 16'd0;
    assign cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [4:0]  r0_shamt, r0_sel, r1_shamt, r1_sel;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt, alu_sel;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        res_valid, res_ready, res_id, res_zero;
    logic [31:0] res_y;
    logic [15:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

`ifdef ALU_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    alu_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_shamt(r0_shamt), .r0_sel(r0_sel),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_shamt(r1_shamt), .r1_sel(r1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_sel(alu_sel),
        .alu_y(alu_y), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_y(res_y), .res_zero(res_zero),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: 00010 add, 00110 subtract, 01000 shift b left by shamt.
    always_comb begin
        case (alu_sel)
            5'b00010: alu_y = alu_a + alu_b;
            5'b00110: alu_y = alu_a - alu_b;
            5'b01000: alu_y = alu_b << alu_shamt;
            default:  alu_y = 32'd0;
        endcase
        alu_zero = (alu_y == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; res_ready = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_a = 32'd0; r0_b = 32'd0; r0_shamt = 5'd0; r0_sel = 5'd0;
        r1_a = 32'd0; r1_b = 32'd0; r1_shamt = 5'd0; r1_sel = 5'd0;
        tick();
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_y", res_y, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_no_ready", 32'({r0_ready, r1_ready}), 32'd0);

        // r0 add 5+7
        r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_sel = 5'b00010;
        #1;
        chk("add_r0_ready", 32'(r0_ready), 32'd1);
        chk("add_r1_ready", 32'(r1_ready), 32'd0);
        tick();
        r0_valid = 1'b0;
        chk("add_alu_a", alu_a, 32'd5);
        chk("add_alu_b", alu_b, 32'd7);
        chk("add_not_valid_yet", 32'(res_valid), 32'd0);
        tick();
        chk("add_res_valid", 32'(res_valid), 32'd1);
        chk("add_res_y", res_y, 32'd12);
        chk("add_res_zero", 32'(res_zero), 32'd0);
        chk("add_res_id", 32'(res_id), 32'd0);
        tick();
        chk("add_drop_valid", 32'(res_valid), 32'd0);
        chk("idle_alu_a_kept", alu_a, 32'd5);

        // r1 subtract 9-9
        r1_valid = 1'b1; r1_a = 32'd9; r1_b = 32'd9; r1_sel = 5'b00110;
        #1;
        chk("sub_r1_ready", 32'(r1_ready), 32'd1);
        tick();
        r1_valid = 1'b0;
        tick();
        chk("sub_res_y", res_y, 32'd0);
        chk("sub_res_zero", 32'(res_zero), 32'd1);
        chk("sub_res_id", 32'(res_id), 32'd1);
        tick();

        // r0 shift 1<<4
        r0_valid = 1'b1; r0_a = 32'd0; r0_b = 32'h1; r0_shamt = 5'd4; r0_sel = 5'b01000;
        tick();
        r0_valid = 1'b0;
        chk("shl_alu_b", alu_b, 32'd1);
        chk("shl_alu_shamt", 32'(alu_shamt), 32'd4);
        chk("shl_alu_sel", 32'(alu_sel), 32'd8);
        tick();
        chk("shl_res_y", res_y, 32'h10);
        tick();
        chk("cnt0_before_rst", 32'(cnt0), 32'(STATS * 2));
        chk("cnt1_before_rst", 32'(cnt1), 32'(STATS * 1));

        // Round-robin from reset: order 0,1,0,1
        reset = 1'b1;
        #1;
        chk("async_rst_alu_b", alu_b, 32'd0);
        tick();
        reset = 1'b0;
        r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_sel = 5'b00010;
        r1_valid = 1'b1; r1_a = 32'd2; r1_b = 32'd3; r1_sel = 5'b00010;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_r0_ready", 32'(r0_ready), 32'((i % 2) == 0));
            chk("rr_r1_ready", 32'(r1_ready), 32'((i % 2) == 1));
            tick();
            tick();
            chk("rr_res_id", 32'(res_id), 32'(i % 2));
            chk("rr_res_y", res_y, ((i % 2) == 1) ? 32'd5 : 32'd2);
            tick();
        end
        chk("rr_cnt0", 32'(cnt0), 32'(STATS * 2));
        chk("rr_cnt1", 32'(cnt1), 32'(STATS * 2));

        // Back-pressure in HOLD for 5 cycles, both requesters still valid
        res_ready = 1'b0;
        r0_a = 32'd3; r0_b = 32'd4;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_y", res_y, 32'd7);
            chk("hold_id", 32'(res_id), 32'd0);
            chk("hold_no_ready", 32'({r0_ready, r1_ready}), 32'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        chk("hold_still_valid", 32'(res_valid), 32'd1);
        tick();
        chk("release_valid_low", 32'(res_valid), 32'd0);
        chk("release_r1_ready", 32'(r1_ready), 32'd1);
        chk("release_r0_ready", 32'(r0_ready), 32'd0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
        tick();
        tick();

        // Reset while an op is in EXEC
        r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd2; r0_sel = 5'b00010;
        tick();
        r0_valid = 1'b0;
        chk("exec_alu_a", alu_a, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_res_valid", 32'(res_valid), 32'd0);
        chk("midrst_res_y", res_y, 32'd0);
        chk("midrst_res_id", 32'(res_id), 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_sel", 32'(alu_sel), 32'd0);
        chk("midrst_cnt0", 32'(cnt0), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_no_pulse1", 32'(res_valid), 32'd0);
        tick();
        chk("midrst_no_pulse2", 32'(res_valid), 32'd0);

        r1_valid = 1'b1; r1_a = 32'd20; r1_b = 32'd22; r1_sel = 5'b00010;
        #1;
        chk("post_r1_ready", 32'(r1_ready), 32'd1);
        tick();
        r1_valid = 1'b0;
        tick();
        chk("post_res_valid", 32'(res_valid), 32'd1);
        chk("post_res_y", res_y, 32'd42);
        chk("post_res_id", 32'(res_id), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, 0, requester index (0/1) granted first after reset on simultaneous requests.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 r0_valid / r1_valid  in  1  requester op available.
REQ-005 r0_ready / r1_ready  out  1  op accepted this cycle when ready&valid.
REQ-006 r0_a, r0_b / r1_a, r1_b  in  32  operands; r0_shamt / r1_shamt  in  5; r0_sel / r1_sel  in  5  ALU select code.
REQ-007 alu_a, alu_b  out  32; alu_shamt, alu_sel  out  5  drive the shared ALU.
REQ-008 alu_y  in  32; alu_zero  in  1  combinational ALU result.
REQ-009 res_valid  out  1; res_ready  in  1; res_id  out  1  granted requester; res_y  out  32; res_zero  out  1.
REQ-010 cnt0, cnt1  out  16  grant counters (see Configuration).

Function
REQ-011 FSM states IDLE, EXEC, HOLD; undefined encodings SHALL go to IDLE next cycle.
REQ-012 rX_ready SHALL be combinational: high only in IDLE and only for the requester selected this cycle; at most one ready high.
REQ-013 Selection in IDLE: single valid -> that requester; both valid -> requester not equal to last_grant (round-robin).
REQ-014 On accept edge (IDLE, ready&valid): latch a/b/shamt/sel into operand regs, last_grant <= id, res_id <= id, state -> EXEC.
REQ-015 alu_a/alu_b/alu_shamt/alu_sel SHALL come from operand regs only; stable through EXEC and HOLD; unchanged in IDLE.
REQ-016 EXEC edge: res_y <= alu_y, res_zero <= alu_zero, res_valid <= 1, state -> HOLD; latency accept edge to res_valid high = 2 edges.
REQ-017 HOLD: res_valid, res_y, res_zero, res_id held stable while res_ready low; no requester accepted.
REQ-018 HOLD edge with res_ready high: res_valid <= 0, state -> IDLE; throughput one op per 3 cycles minimum.
REQ-019 Valid deasserted by requester before accept SHALL cancel nothing already accepted; unaccepted ops are simply not granted.
REQ-020 No valid in IDLE: remain IDLE, both ready low, last_grant unchanged.

Reset
REQ-021 reset SHALL immediately force: state IDLE, res_valid 0, res_y 0, res_zero 0, res_id 0, operand regs and alu_* 0, cnt0/cnt1 0.
REQ-022 last_grant SHALL reset to ~PRIO_INIT so PRIO_INIT wins first contention.
REQ-023 Reset during EXEC or HOLD SHALL discard the in-flight op with no res_valid pulse.

Configuration
REQ-024 Macro ALU_ARB_STATS_EN defined: cnt0/cnt1 increment by 1 on each accept of requester 0/1, saturating at 16'hFFFF.
REQ-025 Macro ALU_ARB_STATS_EN undefined: counter logic absent, cnt0/cnt1 tied to 0; all other behaviour identical.

Verification
REQ-026 r0: a=5, b=7, sel=00010 -> r0_ready same cycle, res_valid 2 edges later, res_y=12, res_zero=0, res_id=0.
REQ-027 r1: a=9, b=9, sel=00110 -> res_y=0, res_zero=1, res_id=1.
REQ-028 PRIO_INIT=0, both valid continuously after reset -> grant order 0,1,0,1; with STATS_EN after 4 results cnt0=2, cnt1=2.
REQ-029 res_ready low 5 cycles in HOLD -> res_valid/res_y/res_id stable, r0_ready/r1_ready low all 5 cycles; accept on release.
REQ-030 reset asserted in EXEC with r0 op a=1, b=2 -> res_valid never rises, all outputs 0, next request served normally.
REQ-031 r0: sel=01000, b=32'h1, shamt=4 -> alu_b=1, alu_shamt=4, res_y=32'h10.
